// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, state/error enums and LFSR step for the traffic checker.
package traffic_pkg;

  localparam logic [7:0] UL_SEED_DEF = 8'hAA;
  localparam logic [7:0] UL_TAPS_DEF = 8'hB4;
  localparam logic [7:0] DL_SEED_DEF = 8'h55;
  localparam logic [7:0] DL_TAPS_DEF = 8'hD8;

  localparam logic PKT_UL = 1'b0;
  localparam logic PKT_DL = 1'b1;

  typedef enum logic [1:0] {HUNT, HALF, LOCKED} chk_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_ID   = 2'b01,
    ERR_TYPE = 2'b10,
    ERR_GAP  = 2'b11
  } err_code_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] taps);
    return {x[6:0], ^(x & taps)};
  endfunction

endpackage

// File: rtl/chk_lfsr8.sv
// rtl/chk_lfsr8.sv - 8-bit reference LFSR; load resyncs to the successor of a received ID.
module chk_lfsr8
  import traffic_pkg::*;
#(
  parameter logic [7:0] TAPS = UL_TAPS_DEF,
  parameter logic [7:0] SEED = UL_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  // A received ID is a full LFSR state, so the next expected ID is its successor.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = lfsr_next(load_val, TAPS);
    end else if (step) begin
      state_d = lfsr_next(state_q, TAPS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/traffic_checker.sv
// rtl/traffic_checker.sv - locks to UL/DL LFSR ID streams and flags ID/type/gap errors.
// Optional spacing check enabled by TRAFFIC_CHK_GAP_CHECK_EN.
module traffic_checker
  import traffic_pkg::*;
#(
  parameter logic [7:0] UL_SEED    = UL_SEED_DEF,
  parameter logic [7:0] UL_TAPS    = UL_TAPS_DEF,
  parameter logic [7:0] DL_SEED    = DL_SEED_DEF,
  parameter logic [7:0] DL_TAPS    = DL_TAPS_DEF,
  parameter int         ERR_THRESH = 4,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       n_period,
  input  logic [7:0]       pkt_id,
  input  logic             pkt_type,
  input  logic             pkt_valid,
  input  logic             clr_stats,
  output logic             locked,
  output logic             ok_pulse,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0]       THRESH  = 4'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t       state_q, state_d;
  err_code_t        code_q, code_d;
  logic             half_type_q, half_type_d;
  logic             exp_type_q, exp_type_d;
  logic [3:0]       bad_run_q, bad_run_d;
  logic             locked_q, locked_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       ul_load, ul_step, dl_load, dl_step;
  logic [7:0] ul_exp, dl_exp, exp_id;
  logic       gap_bad;

  chk_lfsr8 #(.TAPS(UL_TAPS), .SEED(UL_SEED)) u_ul_lfsr (
    .clk(clk), .rst_n(rst_n), .load(ul_load), .load_val(pkt_id), .step(ul_step), .state(ul_exp)
  );

  chk_lfsr8 #(.TAPS(DL_TAPS), .SEED(DL_SEED)) u_dl_lfsr (
    .clk(clk), .rst_n(rst_n), .load(dl_load), .load_val(pkt_id), .step(dl_step), .state(dl_exp)
  );

`ifdef TRAFFIC_CHK_GAP_CHECK_EN
  logic [4:0] gap_cnt_q, gap_cnt_d;
  logic       first_q, first_d;

  // The spacing into the first locked packet is unknown, so it is never judged.
  always_comb begin
    gap_cnt_d = pkt_valid ? 5'd1 : ((gap_cnt_q == 5'd31) ? gap_cnt_q : gap_cnt_q + 5'd1);
    first_d   = first_q;
    if (pkt_valid && state_q == HALF && pkt_type != half_type_q) begin
      first_d = 1'b1;
    end else if (pkt_valid && state_q == LOCKED) begin
      first_d = 1'b0;
    end
    gap_bad = !first_q && (gap_cnt_q != ({1'b0, n_period} + 5'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= 5'd0;
      first_q   <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      first_q   <= first_d;
    end
  end
`else
  assign gap_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    half_type_d = half_type_q;
    exp_type_d  = exp_type_q;
    bad_run_d   = bad_run_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    ul_load     = 1'b0;
    dl_load     = 1'b0;
    ul_step     = 1'b0;
    dl_step     = 1'b0;
    exp_id      = (pkt_type == PKT_DL) ? dl_exp : ul_exp;

    if (pkt_valid) begin
      case (state_q)
        HUNT: begin
          ul_load     = (pkt_type == PKT_UL);
          dl_load     = (pkt_type == PKT_DL);
          half_type_d = pkt_type;
          state_d     = HALF;
        end
        HALF: begin
          ul_load = (pkt_type == PKT_UL);
          dl_load = (pkt_type == PKT_DL);
          if (pkt_type != half_type_q) begin
            exp_type_d = ~pkt_type;
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          // The stream advances even on a bad ID, so one corrupt ID costs one error.
          ul_step    = (pkt_type == PKT_UL);
          dl_step    = (pkt_type == PKT_DL);
          exp_type_d = ~pkt_type;
          if (pkt_cnt_q != CNT_MAX) pkt_cnt_d = pkt_cnt_q + CNT_ONE;
          if (pkt_type != exp_type_q)  code_d = ERR_TYPE;
          else if (pkt_id != exp_id)   code_d = ERR_ID;
          else if (gap_bad)            code_d = ERR_GAP;
          else                         code_d = ERR_NONE;
          if (code_d == ERR_NONE) begin
            ok_d      = 1'b1;
            bad_run_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
            if (bad_run_q + 4'd1 == THRESH) begin
              state_d   = HUNT;
              bad_run_d = 4'd0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr_stats) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      code_q      <= ERR_NONE;
      half_type_q <= PKT_UL;
      exp_type_q  <= PKT_UL;
      bad_run_q   <= 4'd0;
      locked_q    <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      half_type_q <= half_type_d;
      exp_type_q  <= exp_type_d;
      bad_run_q   <= bad_run_d;
      locked_q    <= locked_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign ok_pulse  = ok_q;
  assign err_pulse = err_q;
  assign err_code  = code_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_traffic_checker.sv
// tb/tb_traffic_checker.sv - directed and randomized checks of traffic_checker against a packet-level model.
module tb_traffic_checker;

  localparam int THR = 4;
`ifdef TRAFFIC_CHK_GAP_CHECK_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] n_period = 4'd2;
  logic [7:0] pkt_id = 8'd0;
  logic       pkt_type = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       clr_stats = 1'b0;

  logic        a_locked, a_ok, a_err;
  logic [1:0]  a_code;
  logic [15:0] a_pkt, a_errs;
  logic        b_locked, b_ok, b_err;
  logic [1:0]  b_code;
  logic [3:0]  b_pkt, b_errs;

  traffic_checker #(.ERR_THRESH(THR), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .n_period(n_period), .pkt_id(pkt_id), .pkt_type(pkt_type),
    .pkt_valid(pkt_valid), .clr_stats(clr_stats), .locked(a_locked), .ok_pulse(a_ok),
    .err_pulse(a_err), .err_code(a_code), .pkt_cnt(a_pkt), .err_cnt(a_errs)
  );

  traffic_checker #(.ERR_THRESH(THR), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .n_period(n_period), .pkt_id(pkt_id), .pkt_type(pkt_type),
    .pkt_valid(pkt_valid), .clr_stats(clr_stats), .locked(b_locked), .ok_pulse(b_ok),
    .err_pulse(b_err), .err_code(b_code), .pkt_cnt(b_pkt), .err_cnt(b_errs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference: mode 0=hunting, 1=one stream seen, 2=locked.
  int         m_mode, m_bad, m_cyc, m_last, m_pkt, m_errs;
  bit         m_half, m_exp_ty, m_first;
  logic [7:0] m_ul, m_dl;
  bit         e_locked, e_ok, e_err;
  logic [1:0] e_code;

  function automatic logic [7:0] succ(input logic [7:0] x, input bit dl);
    logic [7:0] t;
    t = dl ? 8'hD8 : 8'hB4;
    return (x << 1) | 8'($countones(x & t) % 2);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bad = 0; m_pkt = 0; m_errs = 0; m_first = 0;
    m_ul = 8'hAA; m_dl = 8'h55; m_exp_ty = 0; m_half = 0; m_last = m_cyc;
    e_locked = 0; e_ok = 0; e_err = 0; e_code = 2'd0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] id, input bit ty, input bit clr);
    int gap;
    int code;
    logic [7:0] want;
    e_ok = 0; e_err = 0;
    if (v) begin
      if (m_mode < 2) begin
        if (ty) m_dl = succ(id, 1); else m_ul = succ(id, 0);
        if (m_mode == 1 && ty != m_half) begin
          m_mode = 2; m_exp_ty = !ty; m_first = 1;
        end else begin
          m_mode = 1; m_half = ty;
        end
      end else begin
        want = ty ? m_dl : m_ul;
        gap = sat(m_cyc - m_last, 31);
        if (ty != m_exp_ty) code = 2;
        else if (id != want) code = 1;
        else if (GAP_EN && !m_first && gap != int'(n_period) + 1) code = 3;
        else code = 0;
        if (ty) m_dl = succ(m_dl, 1); else m_ul = succ(m_ul, 0);
        m_exp_ty = !ty; m_first = 0; m_pkt++;
        e_code = 2'(code);
        if (code == 0) begin
          e_ok = 1; m_bad = 0;
        end else begin
          e_err = 1; m_errs++; m_bad++;
          if (m_bad == THR) begin m_mode = 0; m_bad = 0; end
        end
      end
      m_last = m_cyc;
    end
    if (clr) begin m_pkt = 0; m_errs = 0; end
    e_locked = (m_mode == 2);
    m_cyc++;
  endtask

  task automatic compare_all();
    check("a_locked", a_locked, e_locked);
    check("a_ok", a_ok, e_ok);
    check("a_err", a_err, e_err);
    check("a_code", a_code, e_code);
    check("a_pkt_cnt", a_pkt, sat(m_pkt, 65535));
    check("a_err_cnt", a_errs, sat(m_errs, 65535));
    check("b_locked", b_locked, e_locked);
    check("b_code", b_code, e_code);
    check("b_pkt_cnt", b_pkt, sat(m_pkt, 15));
    check("b_err_cnt", b_errs, sat(m_errs, 15));
  endtask

  task automatic tick(input bit v, input logic [7:0] id, input bit ty, input bit clr);
    @(negedge clk);
    pkt_valid = v; pkt_id = id; pkt_type = ty; clr_stats = clr;
    model_step(v, id, ty, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; pkt_valid = 0; clr_stats = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Well-behaved generator state; stimulus corrupts what it sends, not this.
  logic [7:0] g_ul = 8'hAA, g_dl = 8'h55;
  bit         g_ty = 0;

  task automatic send(input logic [7:0] id, input bit ty, input int idle, input bit clr);
    for (int i = 0; i < idle; i++) tick(0, 8'd0, 0, 0);
    tick(1, id, ty, clr);
  endtask

  // kind: 0 good, 1 bit-flipped ID, 2 repeat of the same type with a correct ID
  task automatic gen_pkt(input int kind, input int idle, input bit clr);
    logic [7:0] id;
    id = g_ty ? g_dl : g_ul;
    if (kind == 1) id = id ^ (8'd1 << $urandom_range(0, 7));
    send(id, g_ty, idle, clr);
    if (g_ty) g_dl = succ(g_dl, 1); else g_ul = succ(g_ul, 0);
    if (kind != 2) g_ty = !g_ty;
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    do_reset();

    n_period = 4'd2;
    for (int i = 0; i < 4; i++) gen_pkt(0, 2, 0);
    check("t1_locked", a_locked, 1);
    check("t1_pkt_cnt", a_pkt, 2);
    check("t1_err_cnt", a_errs, 0);

    gen_pkt(1, 2, 0);
    check("t2_code", a_code, 2'b01);
    check("t2_err_cnt", a_errs, 1);
    gen_pkt(0, 2, 0);
    gen_pkt(0, 2, 0);
    check("t2_locked", a_locked, 1);

    gen_pkt(2, 2, 0);
    gen_pkt(0, 2, 0);
    check("t3_code", a_code, 2'b10);
    gen_pkt(0, 2, 0);
    check("t3_ok", a_ok, 1);

    for (int i = 0; i < THR; i++) gen_pkt(1, 2, 0);
    check("t4_unlocked", a_locked, 0);
    gen_pkt(0, 2, 0);
    gen_pkt(0, 2, 0);
    check("t4_relocked", a_locked, 1);

    n_period = 4'd3;
    gen_pkt(0, 3, 0);
    gen_pkt(0, 3, 0);
    gen_pkt(0, 4, 0);
    check("t5_gap_code", a_code, GAP_EN ? 2'b11 : 2'b00);

    for (int i = 0; i < 20; i++) gen_pkt(0, 3, 0);
    check("t6_sat", b_pkt, 15);
    gen_pkt(0, 3, 1);
    check("t6_clr", b_pkt, 0);
    check("t6_ok", b_ok, 1);

    for (int n = 0; n < 400; n++) begin
      int r, idle;
      r = $urandom_range(0, 99);
      idle = int'(n_period);
      if ($urandom_range(0, 9) == 0) idle = idle + ($urandom_range(0, 1) ? 1 : -1);
      if (idle < 0) idle = 0;
      if (r < 7) gen_pkt(1, idle, 0);
      else if (r < 11) gen_pkt(2, idle, 0);
      else if (r < 12) do_reset();
      else if (r < 14) n_period = 4'($urandom_range(0, 6));
      else gen_pkt(0, idle, ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
